// File: rtl/pipelined_shifter_if.sv
// ---------------------------------------------------------------------------
// pipelined_shifter_if
//
// Bundles the request and result handshakes of the pipelined shifter.
//
// Parameters
//   WIDTH : operand / result width (power of two, >= 4)
//   TAG_W : width of the sideband routing tag
//
// Signals
//   in_valid / in_ready : request handshake
//   in_data             : operand
//   in_amt              : shift / rotate amount (0..WIDTH-1)
//   in_op               : 000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL
//   in_tag              : opaque tag returned with the result
//   out_valid/out_ready : result handshake
//   out_data            : result
//   out_tag             : tag of the result
//   out_err             : result came from an illegal op
//
// Modports
//   slave  : the shifter itself
//   master : whoever issues requests and consumes results
// ---------------------------------------------------------------------------
interface pipelined_shifter_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
);
   localparam int SHW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [SHW-1:0]   in_amt;
   logic [2:0]       in_op;
   logic [TAG_W-1:0] in_tag;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [TAG_W-1:0] out_tag;
   logic             out_err;

   modport slave (
      input  in_valid, in_data, in_amt, in_op, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag, out_err
   );

   modport master (
      output in_valid, in_data, in_amt, in_op, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag, out_err
   );
endinterface

// File: rtl/pipelined_shifter.sv
// ---------------------------------------------------------------------------
// pipelined_shifter
//
// Fully pipelined logarithmic shift / rotate unit. Stage k applies a shift
// of 2^k when bit k of the amount is set and registers the result, so a
// WIDTH-bit unit has $clog2(WIDTH) stages and that many requests in flight.
// Each stage carries a valid bit plus the data, amount, op, tag and error
// flag of its request. A valid/ready handshake with full backpressure sits
// on both ends; results leave in acceptance order.
//
// Parameters
//   WIDTH : data width, power of two, >= 4
//   TAG_W : width of the sideband tag
//
// Ports
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, clears every stage register
//   bus     : request / result handshake (pipelined_shifter_if.slave)
// ---------------------------------------------------------------------------
module pipelined_shifter #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic clock,
   input  logic reset_n,
   pipelined_shifter_if.slave bus
);

   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      OP_SLL = 3'b000,
      OP_SRL = 3'b001,
      OP_SRA = 3'b010,
      OP_ROR = 3'b011,
      OP_ROL = 3'b100
   } shift_op_e;

   // Stage registers; index SHW-1 is the output stage.
   logic [SHW-1:0]   valid_q;
   logic [WIDTH-1:0] data_q [SHW];
   logic [SHW-1:0]   amt_q  [SHW];
   logic [2:0]       op_q   [SHW];
   logic [TAG_W-1:0] tag_q  [SHW];
   logic [SHW-1:0]   err_q;

   // What each stage would capture if it advances this cycle.
   logic [SHW-1:0]   src_valid;
   logic [WIDTH-1:0] src_data   [SHW];
   logic [SHW-1:0]   src_amt    [SHW];
   logic [2:0]       src_op     [SHW];
   logic [TAG_W-1:0] src_tag    [SHW];
   logic [SHW-1:0]   src_err;
   logic [WIDTH-1:0] stage_data [SHW];

   logic [SHW-1:0]   adv;

   // Ops 101..111 have no meaning; they are flagged and their data zeroed.
   function automatic logic is_illegal(input logic [2:0] op);
      return op > OP_ROL;
   endfunction

   // One mux level: shift or rotate by a fixed power of two. SRA refills
   // with the current MSB, which is still the original sign bit because
   // every earlier level also replicated it.
   function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                    input logic [2:0]       op,
                                                    input int               s);
      logic [WIDTH-1:0] r;
      case (op)
         OP_SLL:  r = d << s;
         OP_SRL:  r = d >> s;
         OP_SRA:  r = $signed(d) >>> s;
         OP_ROR:  r = (d >> s) | (d << (WIDTH - s));
         OP_ROL:  r = (d << s) | (d >> (WIDTH - s));
         default: r = '0;
      endcase
      return r;
   endfunction

   // Backpressure chain, evaluated from the output back to the input. A
   // stage may move when it is empty or when the stage after it moves, so
   // a full pipeline still drains and refills on the same edge. in_valid
   // never enters this chain, which keeps in_ready free of any path from it.
   always_comb begin
      adv = '0;
      adv[SHW-1] = ~valid_q[SHW-1] | bus.out_ready;
      for (int k = SHW - 2; k >= 0; k--) begin
         adv[k] = ~valid_q[k] | adv[k + 1];
      end
   end

   // Stage inputs: stage 0 takes the request ports directly, every later
   // stage takes the register in front of it. The level shift for each
   // stage is applied here so the register captures the shifted value.
   always_comb begin
      src_valid = '0;
      src_err   = '0;
      for (int k = 0; k < SHW; k++) begin
         src_data[k]   = '0;
         src_amt[k]    = '0;
         src_op[k]     = '0;
         src_tag[k]    = '0;
         stage_data[k] = '0;
      end

      src_valid[0] = bus.in_valid;
      src_err[0]   = is_illegal(bus.in_op);
      src_data[0]  = is_illegal(bus.in_op) ? '0 : bus.in_data;
      src_amt[0]   = bus.in_amt;
      src_op[0]    = bus.in_op;
      src_tag[0]   = bus.in_tag;

      for (int k = 1; k < SHW; k++) begin
         src_valid[k] = valid_q[k - 1];
         src_err[k]   = err_q[k - 1];
         src_data[k]  = data_q[k - 1];
         src_amt[k]   = amt_q[k - 1];
         src_op[k]    = op_q[k - 1];
         src_tag[k]   = tag_q[k - 1];
      end

      for (int k = 0; k < SHW; k++) begin
         stage_data[k] = src_amt[k][k] ? shift_level(src_data[k], src_op[k], 1 << k)
                                       : src_data[k];
      end
   end

   // Stage registers. A stage that cannot advance keeps everything. A stage
   // that advances always takes the upstream valid bit, but only overwrites
   // its payload when a real request arrives, so a bubble leaves the last
   // result visible instead of toggling the datapath.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         err_q   <= '0;
         for (int k = 0; k < SHW; k++) begin
            data_q[k] <= '0;
            amt_q[k]  <= '0;
            op_q[k]   <= '0;
            tag_q[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < SHW; k++) begin
            if (adv[k]) begin
               valid_q[k] <= src_valid[k];
               if (src_valid[k]) begin
                  data_q[k] <= stage_data[k];
                  amt_q[k]  <= src_amt[k];
                  op_q[k]   <= src_op[k];
                  tag_q[k]  <= src_tag[k];
                  err_q[k]  <= src_err[k];
               end
            end
         end
      end
   end

   assign bus.in_ready  = adv[0];
   assign bus.out_valid = valid_q[SHW - 1];
   assign bus.out_data  = data_q[SHW - 1];
   assign bus.out_tag   = tag_q[SHW - 1];
   assign bus.out_err   = err_q[SHW - 1];

endmodule

// File: tb/tb_pipelined_shifter.sv
// ---------------------------------------------------------------------------
// tb_pipelined_shifter
//
// Drives a 32-bit and an 8-bit pipelined_shifter. Every accepted request is
// turned into an expected result by a whole-amount arithmetic model and
// queued; every cycle a result is presented it must match the queue head.
// Directed sequences cover latency, back-to-back issue, backpressure,
// illegal ops and asynchronous reset, followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_pipelined_shifter;

   logic clock = 1'b0;
   logic reset_n;

   always #5 clock = ~clock;

   pipelined_shifter_if #(.WIDTH(32), .TAG_W(4)) bus32 ();
   pipelined_shifter_if #(.WIDTH(8),  .TAG_W(4)) bus8 ();

   pipelined_shifter #(.WIDTH(32), .TAG_W(4)) dut32 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus32)
   );

   pipelined_shifter #(.WIDTH(8), .TAG_W(4)) dut8 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus8)
   );

   typedef struct {
      logic [31:0] data;
      logic [3:0]  tag;
      logic        err;
   } exp_t;

   exp_t exp32[$];
   exp_t exp8[$];

   int checks     = 0;
   int errors     = 0;
   int out_count32 = 0;
   int out_count8  = 0;

   // Single comparison point for the whole bench.
   task automatic check_output(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference: the full shift applied at once with wide arithmetic.
   function automatic logic [31:0] ref_shift(input int w, input logic [31:0] d,
                                             input int amt, input logic [2:0] op);
      logic [63:0] mask, x, r;
      mask = (64'd1 << w) - 64'd1;
      x    = {32'd0, d} & mask;
      case (op)
         3'd0: r = x << amt;
         3'd1: r = x >> amt;
         3'd2: begin
            r = x >> amt;
            if (x[w-1]) r = r | (mask & ~(mask >> amt));
         end
         3'd3: r = (x >> amt) | (x << (w - amt));
         3'd4: r = (x << amt) | (x >> (w - amt));
         default: r = 64'd0;
      endcase
      return 32'(r & mask);
   endfunction

   // Scoreboards, sampled mid-cycle so every handshake signal is settled.
   always @(negedge clock) begin
      exp_t e;
      if (reset_n) begin
         if (bus32.out_valid) begin
            if (exp32.size() == 0) begin
               check_output("w32_unexpected_result", 64'(exp32.size()), 64'd1);
            end else begin
               check_output("w32_data", bus32.out_data, exp32[0].data);
               check_output("w32_tag",  bus32.out_tag,  exp32[0].tag);
               check_output("w32_err",  bus32.out_err,  exp32[0].err);
               if (bus32.out_ready) begin
                  void'(exp32.pop_front());
                  out_count32++;
               end
            end
         end
         if (bus32.in_valid && bus32.in_ready) begin
            e.data = ref_shift(32, bus32.in_data, int'(bus32.in_amt), bus32.in_op);
            e.tag  = bus32.in_tag;
            e.err  = (bus32.in_op > 3'd4);
            exp32.push_back(e);
         end

         if (bus8.out_valid) begin
            if (exp8.size() == 0) begin
               check_output("w8_unexpected_result", 64'(exp8.size()), 64'd1);
            end else begin
               check_output("w8_data", bus8.out_data, exp8[0].data);
               check_output("w8_tag",  bus8.out_tag,  exp8[0].tag);
               check_output("w8_err",  bus8.out_err,  exp8[0].err);
               if (bus8.out_ready) begin
                  void'(exp8.pop_front());
                  out_count8++;
               end
            end
         end
         if (bus8.in_valid && bus8.in_ready) begin
            e.data = ref_shift(8, {24'd0, bus8.in_data}, int'(bus8.in_amt), bus8.in_op);
            e.tag  = bus8.in_tag;
            e.err  = (bus8.in_op > 3'd4);
            exp8.push_back(e);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Presents one request and holds it until accepted (bounded).
   task automatic apply_stimulus(input bit narrow, input logic [31:0] d,
                                 input logic [4:0] amt, input logic [2:0] op,
                                 input logic [3:0] tag);
      bit done = 1'b0;
      if (narrow) begin
         bus8.in_data  = d[7:0];
         bus8.in_amt   = amt[2:0];
         bus8.in_op    = op;
         bus8.in_tag   = tag;
         bus8.in_valid = 1'b1;
      end else begin
         bus32.in_data  = d;
         bus32.in_amt   = amt;
         bus32.in_op    = op;
         bus32.in_tag   = tag;
         bus32.in_valid = 1'b1;
      end
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clock);
         done = narrow ? bus8.in_ready : bus32.in_ready;
         @(posedge clock);
         #1;
      end
      bus8.in_valid  = 1'b0;
      bus32.in_valid = 1'b0;
      check_output(narrow ? "w8_accept" : "w32_accept", 64'(done), 64'd1);
   endtask

   // Called right after the accepting edge; counts edges up to out_valid.
   task automatic measure_latency(input bit narrow, input int expect_edges, input string name);
      int edges = 1;
      bit seen  = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         seen = narrow ? bus8.out_valid : bus32.out_valid;
         if (!seen) begin
            step(1);
            edges++;
         end
      end
      check_output(name, 64'(edges), 64'(expect_edges));
   endtask

   task automatic drain(input bit narrow);
      for (int i = 0; i < 100 && (narrow ? exp8.size() : exp32.size()) != 0; i++) step(1);
      check_output(narrow ? "w8_drained" : "w32_drained",
                   64'(narrow ? exp8.size() : exp32.size()), 64'd0);
   endtask

   task automatic random_phase(input bit narrow, input int total);
      int sent = 0;
      bit fire;
      logic [2:0] op;
      for (int cyc = 0; cyc < total * 20 && sent < total; cyc++) begin
         if (!(narrow ? bus8.in_valid : bus32.in_valid) && $urandom_range(0, 3) != 0) begin
            op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            if (narrow) begin
               bus8.in_data  = 8'($urandom);
               bus8.in_amt   = 3'($urandom_range(0, 7));
               bus8.in_op    = op;
               bus8.in_tag   = 4'($urandom_range(0, 15));
               bus8.in_valid = 1'b1;
            end else begin
               bus32.in_data  = $urandom;
               bus32.in_amt   = 5'($urandom_range(0, 31));
               bus32.in_op    = op;
               bus32.in_tag   = 4'($urandom_range(0, 15));
               bus32.in_valid = 1'b1;
            end
         end
         if (narrow) bus8.out_ready = ($urandom_range(0, 3) != 0);
         else        bus32.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clock);
         fire = narrow ? (bus8.in_valid && bus8.in_ready) : (bus32.in_valid && bus32.in_ready);
         @(posedge clock);
         #1;
         if (fire) begin
            sent++;
            if (narrow) bus8.in_valid = 1'b0;
            else        bus32.in_valid = 1'b0;
         end
      end
      bus8.in_valid   = 1'b0;
      bus32.in_valid  = 1'b0;
      bus8.out_ready  = 1'b1;
      bus32.out_ready = 1'b1;
      check_output(narrow ? "w8_random_sent" : "w32_random_sent", 64'(sent), 64'(total));
      drain(narrow);
   endtask

   initial begin
      logic [31:0] b2b_exp [4];
      int          base;
      bit          hit;

      reset_n = 1'b0;
      bus32.in_valid = 1'b0; bus32.in_data = '0; bus32.in_amt = '0;
      bus32.in_op = '0; bus32.in_tag = '0; bus32.out_ready = 1'b1;
      bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_amt = '0;
      bus8.in_op = '0; bus8.in_tag = '0; bus8.out_ready = 1'b1;

      // Reset state
      step(3);
      check_output("reset_out_valid", bus32.out_valid, 1'b0);
      check_output("reset_out_data",  bus32.out_data,  32'd0);
      check_output("reset_out_tag",   bus32.out_tag,   4'd0);
      check_output("reset_out_err",   bus32.out_err,   1'b0);
      check_output("reset_in_ready",  bus32.in_ready,  1'b1);
      check_output("reset_w8_valid",  bus8.out_valid,  1'b0);
      reset_n = 1'b1;

      // SRA of the sign bit all the way across, five-edge latency
      apply_stimulus(1'b0, 32'h8000_0000, 5'd31, 3'b010, 4'd3);
      measure_latency(1'b0, 5, "w32_latency");
      check_output("sra_data", bus32.out_data, 32'hFFFF_FFFF);
      check_output("sra_tag",  bus32.out_tag,  4'd3);
      check_output("sra_err",  bus32.out_err,  1'b0);
      step(2);

      // Back-to-back issue, four consecutive results
      b2b_exp[0] = 32'h0800_0000; b2b_exp[1] = 32'hFFFF_0000;
      b2b_exp[2] = 32'h8000_0000; b2b_exp[3] = 32'h0000_0018;
      apply_stimulus(1'b0, 32'h8000_0000, 5'd4,  3'b001, 4'd4);
      apply_stimulus(1'b0, 32'hFFFF_FFFF, 5'd16, 3'b000, 4'd5);
      apply_stimulus(1'b0, 32'h0000_0001, 5'd1,  3'b011, 4'd6);
      apply_stimulus(1'b0, 32'h8000_0001, 5'd4,  3'b100, 4'd7);
      for (int i = 0; i < 20 && !bus32.out_valid; i++) step(1);
      for (int i = 0; i < 4; i++) begin
         check_output("b2b_valid", bus32.out_valid, 1'b1);
         check_output("b2b_data",  bus32.out_data,  b2b_exp[i]);
         step(1);
      end
      drain(1'b0);

      // Backpressure: five fill the pipe, the rest wait for out_ready
      base = out_count32;
      bus32.out_ready = 1'b0;
      for (int t = 0; t < 5; t++) apply_stimulus(1'b0, $urandom, 5'($urandom_range(0, 31)),
                                                  3'($urandom_range(0, 4)), 4'(t));
      check_output("bp_in_ready_low", bus32.in_ready, 1'b0);
      step(4);
      check_output("bp_still_full",  bus32.in_ready,  1'b0);
      check_output("bp_head_valid",  bus32.out_valid, 1'b1);
      check_output("bp_head_tag",    bus32.out_tag,   4'd0);
      bus32.out_ready = 1'b1;
      for (int t = 5; t < 8; t++) apply_stimulus(1'b0, $urandom, 5'($urandom_range(0, 31)),
                                                  3'($urandom_range(0, 4)), 4'(t));
      drain(1'b0);
      check_output("bp_result_count", 64'(out_count32 - base), 64'd8);

      // Illegal op between two legal neighbours
      apply_stimulus(1'b0, 32'h0000_00F0, 5'd3, 3'b000, 4'd8);
      apply_stimulus(1'b0, 32'h1234_5678, 5'd7, 3'b110, 4'd9);
      apply_stimulus(1'b0, 32'hF000_0000, 5'd2, 3'b001, 4'd10);
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         hit = bus32.out_valid && (bus32.out_tag == 4'd9);
         if (!hit) step(1);
      end
      check_output("illegal_tag",  bus32.out_tag,  4'd9);
      check_output("illegal_data", bus32.out_data, 32'd0);
      check_output("illegal_err",  bus32.out_err,  1'b1);
      drain(1'b0);

      // Asynchronous reset with three requests in flight
      bus32.out_ready = 1'b0;
      apply_stimulus(1'b0, 32'h0000_0011, 5'd1, 3'b000, 4'd11);
      apply_stimulus(1'b0, 32'h0000_0022, 5'd1, 3'b000, 4'd12);
      apply_stimulus(1'b0, 32'h0000_0033, 5'd1, 3'b000, 4'd13);
      step(3);
      check_output("rst_pre_valid", bus32.out_valid, 1'b1);
      #1;
      reset_n = 1'b0;
      exp32.delete();
      #1;
      check_output("rst_out_valid", bus32.out_valid, 1'b0);
      check_output("rst_out_data",  bus32.out_data,  32'd0);
      check_output("rst_out_tag",   bus32.out_tag,   4'd0);
      check_output("rst_out_err",   bus32.out_err,   1'b0);
      step(2);
      reset_n = 1'b1;
      bus32.out_ready = 1'b1;
      base = out_count32;
      apply_stimulus(1'b0, 32'h0000_0100, 5'd8, 3'b001, 4'd14);
      measure_latency(1'b0, 5, "rst_after_latency");
      check_output("rst_after_data", bus32.out_data, 32'h0000_0001);
      drain(1'b0);
      step(3);
      check_output("rst_no_stale", 64'(out_count32 - base), 64'd1);

      // Randomized traffic, 32-bit
      random_phase(1'b0, 200);

      // 8-bit instance: directed then randomized
      apply_stimulus(1'b1, 32'h0000_0090, 5'd3, 3'b010, 4'd1);
      measure_latency(1'b1, 3, "w8_latency_sra");
      check_output("w8_sra_data", bus8.out_data, 8'hF2);
      step(2);
      apply_stimulus(1'b1, 32'h0000_0081, 5'd1, 3'b100, 4'd2);
      measure_latency(1'b1, 3, "w8_latency_rol");
      check_output("w8_rol_data", bus8.out_data, 8'h03);
      drain(1'b1);
      random_phase(1'b1, 80);

      step(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, fully pipelined logarithmic shift/rotate unit for the multdiv/ALU datapath.
- Extends the single-cycle arithmetic right shifter with:
  - configurable width;
  - five operations (SLL, SRL, SRA, ROR, ROL);
  - one pipeline register per mux level;
  - valid/ready handshake with full backpressure;
  - a sideband tag for result routing.

Parameters:
- WIDTH, 32: data width. Must be a power of two, ≥ 4.
- TAG_W, 4: width of the sideband tag carried alongside each operation.
- SHW, $clog2(WIDTH): derived, not overridden. Shift-amount width and number of pipeline levels (L = SHW).

Ports:
- clock, input, 1: single clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: request valid.
- in_ready, output, 1: unit can accept a request this cycle.
- in_data, input, WIDTH: operand.
- in_amt, input, SHW: shift/rotate amount (0..WIDTH-1).
- in_op, input, 3: 000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL; 101–111 illegal.
- in_tag, input, TAG_W: opaque tag, returned unchanged.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts result.
- out_data, output, WIDTH: result.
- out_tag, output, TAG_W: tag of the result.
- out_err, output, 1: result came from an illegal op.

Behaviour:
- Clock and reset are fixed:
  - one clock, `clock`;
  - reset is asynchronous and active-low on `reset_n`.
- While reset_n = 0, all of these are 0:
  - every stage valid bit, data, amt, op, tag and err register;
  - therefore out_valid, out_data, out_tag and out_err.
- in_ready is combinational and is not gated by reset state.
- Pipeline structure:
  - L stages. Stage k (k = 0..L-1) applies a shift of 2^k when amt bit k is 1, then registers the result.
  - Stage 0 is combinational from the in_* ports into register 0.
  - Outputs are driven directly from register L-1.
- Latency: a request accepted at edge E appears on out_* after edge E+L-1.
  - WIDTH = 32: accepted at edge 1, visible after edge 5.
- Throughput: one request per cycle when out_ready = 1.
- Handshake:
  - Transfer occurs when valid and ready are both 1 on a rising edge.
  - adv[L-1] = !v[L-1] | out_ready.
  - adv[k] = !v[k] | adv[k+1].
  - in_ready = adv[0].
  - Ready chain is combinational; no combinational path from in_valid to in_ready.
- Stall: a stage that does not advance holds its data, amt, op, tag and err unchanged.
- Bubbles: a stage with v = 0 may load regardless of downstream state.
- Output stability: while out_valid = 1 and out_ready = 0, out_data, out_tag and out_err must not change.
- Capacity: L entries in flight. With out_ready held low, in_ready falls after L accepts.
- Per-level operation (shift by s = 2^k):
  - SLL: zero fill from LSB.
  - SRL: zero fill from MSB.
  - SRA: fill with the current stage's MSB. Sign is preserved across stages because the MSB is the original sign.
  - ROR / ROL: bits wrap around.
- in_amt = 0: result equals operand for all legal ops.
- Illegal op:
  - Data is forced to 0 at stage 0; err = 1 travels with the request.
  - Tag is returned; no other effect on the pipeline.
- Order: results leave in acceptance order; tags are never reordered.
- Reset mid-operation: all in-flight requests are discarded with no output. First accept is possible on the first edge after reset_n rises.
- Simultaneous events: a stage may be drained and refilled on the same edge. A full pipeline with out_ready = 1 accepts a new request every cycle.

Test Plan:
- WIDTH=32, SRA 0x80000000 amt 31, tag 3 → after 5 edges: out_data 0xFFFFFFFF, out_tag 3, out_err 0.
- Back-to-back, one per cycle:
  - SRL 0x80000000 amt 4 → 0x08000000;
  - SLL 0xFFFFFFFF amt 16 → 0xFFFF0000;
  - ROR 0x00000001 amt 1 → 0x80000000;
  - ROL 0x80000001 amt 4 → 0x00000018.
  - Required: four consecutive out_valid cycles in order.
- Backpressure: out_ready = 0, drive 8 requests with tags 0..7.
  - in_ready drops after the 5th accept; outputs stay stable.
  - Then raise out_ready → tags 0..7 emerge in order, none lost or duplicated.
- Illegal op 110 with data 0x12345678, tag 9 → out_data 0, out_err 1, out_tag 9. Neighbouring legal ops unaffected.
- Pull reset_n low with 3 requests in flight:
  - out_valid goes 0 immediately (asynchronous), all outputs 0.
  - After release, the next request emerges with latency 5 and no stale results appear.
- WIDTH=8 instance, SRA 0x90 amt 3 → 0xF2; ROL 0x81 amt 1 → 0x03. Latency 3.
